// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment sequencer: access encodings,
// sequencer states and access-size helpers.
package lsu_pkg;

    // Data memory access-type encodings
    localparam logic [2:0] CtrlB  = 3'b000;
    localparam logic [2:0] CtrlH  = 3'b001;
    localparam logic [2:0] CtrlW  = 3'b010;
    localparam logic [2:0] CtrlBu = 3'b100;
    localparam logic [2:0] CtrlHu = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StSplit,
        StDone
    } lsu_state_e;

    // Access size in bytes; 0 marks an encoding with no defined access
    function automatic logic [2:0] size_of(input logic [2:0] ctrl);
        logic [2:0] n;
        case (ctrl)
            CtrlB, CtrlBu: n = 3'd1;
            CtrlH, CtrlHu: n = 3'd2;
            CtrlW:         n = 3'd4;
            default:       n = 3'd0;
        endcase
        return n;
    endfunction

    // Unsigned variants have no store counterpart
    function automatic logic is_legal(input logic [2:0] ctrl, input logic wr);
        return (size_of(ctrl) != 3'd0) && !(wr && ctrl[2]);
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load extension: trims a little-endian assembled value to the access size and
// sign- or zero-extends it to 32 bits.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  ctrl,
    input  logic [31:0] raw,
    output logic [31:0] result
);

    // Pick width and extension from the access type
    always_comb begin
        result = '0;
        case (ctrl)
            CtrlB:   result = {{24{raw[7]}}, raw[7:0]};
            CtrlBu:  result = {24'b0, raw[7:0]};
            CtrlH:   result = {{16{raw[15]}}, raw[15:0]};
            CtrlHu:  result = {16'b0, raw[15:0]};
            CtrlW:   result = raw;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store sequencer between the core and a byte-addressed data memory.
// Aligned and byte accesses pass straight through; misaligned halfword/word
// accesses are broken into byte accesses while the core is stalled, and the
// load bytes are reassembled and extended in a final DONE cycle.
// Build option LSU_MISALIGN_TRAP_EN: misaligned requests are suppressed and
// only flagged on `misaligned`, so the core can raise an exception instead.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            MemWr,
    input  logic [2:0]      MemCtrl,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            stall,
    output logic            misaligned,
    output logic            DMWr,
    output logic [2:0]      DMCtrl,
    output logic [XLEN-1:0] dm_addr,
    output logic [XLEN-1:0] DataWr,
    input  logic [XLEN-1:0] DataRd
);

    lsu_state_e      state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] byte_buf_q, byte_buf_d;

    logic [2:0]      size;
    logic            legal;
    logic            last_byte;
    logic [XLEN-1:0] wdata_shift;
    logic [XLEN-1:0] ext_raw;
    logic [XLEN-1:0] ext_data;

    assign size        = size_of(MemCtrl);
    assign legal       = is_legal(MemCtrl, MemWr);
    assign misaligned  = req & (((size == 3'd2) & addr[0]) |
                                ((size == 3'd4) & (addr[1:0] != 2'b00)));
    assign last_byte   = ({1'b0, cnt_q} == (size - 3'd1));
    assign wdata_shift = wdata >> {cnt_q, 3'b000};

    // Buffered bytes feed the extender only once the split has finished
    assign ext_raw = (state_q == StDone) ? byte_buf_q : DataRd;

    lsu_load_ext u_load_ext (
        .ctrl   (MemCtrl),
        .raw    (ext_raw),
        .result (ext_data)
    );

    // Sequencer state, byte counter and reassembly buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 2'd0;
            byte_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_buf_q <= byte_buf_d;
        end
    end

    // Next state and memory-side / core-side outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_buf_d = byte_buf_q;
        stall      = 1'b0;
        DMWr       = req & MemWr & legal;
        DMCtrl     = MemCtrl;
        dm_addr    = addr;
        DataWr     = wdata;
        rdata      = legal ? (MemWr ? DataRd : ext_data) : '0;

        unique case (state_q)
            StIdle: begin
                if (misaligned && legal) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    DMWr  = 1'b0;
                    rdata = '0;
`else
                    stall      = 1'b1;
                    DMWr       = MemWr;
                    DMCtrl     = MemWr ? CtrlB : CtrlBu;
                    DataWr     = {{(XLEN-8){1'b0}}, wdata[7:0]};
                    rdata      = '0;
                    byte_buf_d = {{(XLEN-8){1'b0}}, DataRd[7:0]};
                    cnt_d      = 2'd1;
                    state_d    = StSplit;
`endif
                end
            end
            StSplit: begin
                stall   = 1'b1;
                DMWr    = MemWr;
                DMCtrl  = MemWr ? CtrlB : CtrlBu;
                dm_addr = addr + {{(XLEN-2){1'b0}}, cnt_q};
                DataWr  = {{(XLEN-8){1'b0}}, wdata_shift[7:0]};
                rdata   = '0;
                byte_buf_d[{cnt_q, 3'b000} +: 8] = DataRd[7:0];
                if (last_byte) begin
                    state_d = StDone;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StDone: begin
                // Core advances on this edge, so the request is not re-issued
                DMWr    = 1'b0;
                rdata   = MemWr ? '0 : ext_data;
                state_d = StIdle;
                cnt_d   = 2'd0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 2'd0;
            end
        endcase

        if (rst) begin
            stall = 1'b0;
            DMWr  = 1'b0;
            rdata = '0;
        end
    end

endmodule
